ctrl_50mhz: RTL
===============

Name: ctrl_50mhz

Overview:
Input stage on the 50 MHz side of the packet path; it drives the write side of the clock-crossing FIFO whose read side the 2 MHz controller drains.
- Deserializes a serial bit stream, qualified by data_ena, into bytes.
- Pulses a one-cycle FIFO write per completed byte.
- Tracks byte position within a packet so the 2 MHz side's fixed grouping stays aligned.
- Flags overflow and short packets.

Parameters:
BYTES_PER_PKT, 4, bytes per packet; must match the 2 MHz accumulation group size.
BIT_W, 8, bits per byte / FIFO data width.

Ports:
clk  input  1  50 MHz clock, all logic on posedge.
reset_n  input  1  asynchronous active-low reset.
serial_data  input  1  serial data bit, MSB first, valid when data_ena=1.
data_ena  input  1  high for the whole packet, low between packets.
fifo_full  input  1  FIFO full flag, same clock domain.
fifo_data  output  BIT_W  assembled byte, direct from the shift register.
wr_fifo  output  1  registered one-cycle FIFO write strobe.
pkt_done  output  1  registered one-cycle pulse with the write of the last byte of a packet.
overflow  output  1  sticky; a byte was dropped because fifo_full.
short_pkt  output  1  sticky; data_ena fell with a partial byte or partial packet.

Behaviour:
Reset:
- Reset is asynchronous, active-low (reset_n); single clock clk.
- All outputs 0; shift register 0; bit_cnt=0; byte_idx=0; rx FSM in IDLE.
- Reset mid-byte or mid-packet discards all partial state; no write is issued.

RX FSM (rx_ps) states:
- IDLE: wait for data_ena=1.
- RX: sample bits.
- Transitions:
  - IDLE->RX and RX->RX on data_ena=1.
  - RX->IDLE on data_ena=0.
- The first bit is sampled in the same cycle data_ena is first seen high (no idle bubble).

Shift register:
- Each cycle with data_ena=1: sreg <= {sreg[BIT_W-2:0], serial_data}; bit_cnt increments mod BIT_W.
- fifo_data = sreg. It holds after completion until the next bit of the following byte is sampled, i.e. it is stable during wr_fifo.

Write FSM (wr_ps) states:
- NO_WR: on the edge where the bit with bit_cnt==BIT_W-1 is sampled:
  - if fifo_full=0, go to WR.
  - else stay in NO_WR and set overflow.
- WR: wr_fifo=1 for exactly one cycle, then NO_WR.
- Latency: wr_fifo is high in the cycle immediately after the 8th-bit edge.
- Back-to-back bytes give one wr_fifo every BIT_W cycles.

byte_idx and pkt_done:
- byte_idx increments mod BYTES_PER_PKT on each completed byte, whether it was written or dropped.
- pkt_done=1 together with wr_fifo when the completed byte had byte_idx==BYTES_PER_PKT-1.
- A dropped last byte gives no pkt_done.

Boundary conditions:
- fifo_full is sampled only on the completion edge. A full that asserts later does not retract an issued write.
- data_ena falls with bit_cnt!=0 or byte_idx!=0: set short_pkt, clear bit_cnt and byte_idx, no write for the partial byte.
- data_ena falls in the same cycle as the 8th bit: that bit is not sampled (data_ena=0), so it is treated as a partial byte.
- A data_ena glitch high for fewer than 8 cycles yields short_pkt and no write.
- Sticky flags clear only on reset.
- bit_cnt is $clog2(BIT_W) bits; byte_idx is $clog2(BYTES_PER_PKT) bits, minimum 1. Wrap is natural, no saturation.

Decomposition:
- Package ctrl_pkg holds:
  - enums rx_state_t {IDLE, RX} and wr_state_t {NO_WR, WR};
  - constants BIT_W and BYTES_PER_PKT defaults, shared with ctrl_2mhz so the group size is defined once.
- One sub-module is natural: sipo_shift (BIT_W-wide serial-in/parallel-out shift register with enable).
- Counters and FSMs stay in ctrl_50mhz.

Test Plan:
1. Reset, then data_ena high 32 cycles, serial stream bytes 0xA5,0x3C,0xFF,0x01 MSB first -> four wr_fifo pulses, at cycles 8,16,24,32 after the first sample edge; fifo_data=0xA5,0x3C,0xFF,0x01 at each pulse; pkt_done only with 0x01; flags 0.
2. Two packets back to back with data_ena held high for 64 cycles -> 8 writes exactly 8 cycles apart; pkt_done on the 4th and 8th.
3. fifo_full=1 during the completion edge of byte 2 (0x3C) -> no write for 0x3C; overflow=1 and stays 1; bytes 3 and 4 are still written; pkt_done with byte 4.
4. data_ena falls after 13 bits -> exactly 1 write (byte 1), short_pkt=1; the next full packet writes 4 bytes with pkt_done on its 4th byte (indices realigned).
5. reset_n asserted asynchronously mid-cycle at bit 5 of byte 3 -> all outputs 0 immediately; after release a fresh packet 0x11,0x22,0x33,0x44 is written correctly with pkt_done on 0x44.
6. fifo_full rises in the same cycle wr_fifo=1 -> the write still completes; the following byte is dropped only if full is still high at its completion edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and packet geometry for the 50 MHz / 2 MHz packet path
//
// Purpose: one definition of byte width and packet group size, shared by
// ctrl_50mhz and ctrl_2mhz so both sides of the FIFO agree on grouping.
// Ports: none (package).
package ctrl_pkg;

  localparam int CTRL_BIT_W         = 8;
  localparam int CTRL_BYTES_PER_PKT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RX   = 1'b1
  } rx_state_t;

  typedef enum logic {
    NO_WR = 1'b0,
    WR    = 1'b1
  } wr_state_t;

endpackage

// File: rtl/sipo_shift.sv
// rtl/sipo_shift.sv - serial-in/parallel-out shift register with enable
//
// Purpose: shifts din_i in at the LSB each enabled cycle, so the first bit
// received ends up as the MSB after W shifts.
// Ports:
//   clk_i   - clock, posedge
//   rst_ni  - asynchronous active-low reset, clears the register
//   en_i    - shift enable
//   din_i   - serial input bit
//   dout_o  - parallel register contents
module sipo_shift #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         din_i,
  output logic [W-1:0] dout_o
);

  logic [W-1:0] sreg_q;
  logic [W-1:0] sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (en_i) begin
      sreg_d = {sreg_q[W-2:0], din_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign dout_o = sreg_q;

endmodule

// File: rtl/ctrl_50mhz.sv
// rtl/ctrl_50mhz.sv - 50 MHz serial-to-byte input stage driving the CDC FIFO write side
//
// Purpose: deserializes a data_ena-qualified MSB-first bit stream into bytes,
// issues one registered FIFO write per completed byte, tracks byte position
// in the packet and flags overflow / short packets.
// Ports:
//   clk         - 50 MHz clock, posedge
//   reset_n     - asynchronous active-low reset
//   serial_data - serial bit, valid while data_ena=1
//   data_ena    - high for the whole packet
//   fifo_full   - FIFO full flag, sampled on the byte completion edge only
//   fifo_data   - assembled byte, straight from the shift register
//   wr_fifo     - one-cycle write strobe, cycle after the last bit edge
//   pkt_done    - one-cycle pulse with the write of a packet's last byte
//   overflow    - sticky, a completed byte was dropped on fifo_full
//   short_pkt   - sticky, data_ena fell with a partial byte or packet
module ctrl_50mhz
  import ctrl_pkg::*;
#(
  parameter int BIT_W         = CTRL_BIT_W,
  parameter int BYTES_PER_PKT = CTRL_BYTES_PER_PKT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_data,
  input  logic             data_ena,
  input  logic             fifo_full,
  output logic [BIT_W-1:0] fifo_data,
  output logic             wr_fifo,
  output logic             pkt_done,
  output logic             overflow,
  output logic             short_pkt
);

  localparam int CNT_W = $clog2(BIT_W);
  localparam int IDX_W = (BYTES_PER_PKT > 1) ? $clog2(BYTES_PER_PKT) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_PKT - 1);

  rx_state_t        rx_ps_q, rx_ps_d;
  wr_state_t        wr_ps_q, wr_ps_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic             pkt_done_q, pkt_done_d;
  logic             overflow_q, overflow_d;
  logic             short_q, short_d;
  logic             byte_done;

  // The bit sampled this edge completes a byte.
  assign byte_done = data_ena && (bit_cnt_q == LAST_BIT);

  sipo_shift #(
    .W (BIT_W)
  ) u_sipo (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .en_i   (data_ena),
    .din_i  (serial_data),
    .dout_o (fifo_data)
  );

  always_comb begin
    rx_ps_d    = data_ena ? RX : IDLE;
    wr_ps_d    = NO_WR;
    pkt_done_d = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    overflow_d = overflow_q;
    short_d    = short_q;

    if (data_ena) begin
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
      if (byte_done) begin
        // Position advances for dropped bytes too, so the 2 MHz grouping
        // stays aligned with the sender's packet boundaries.
        byte_idx_d = (byte_idx_q == LAST_IDX) ? '0 : byte_idx_q + 1'b1;
        if (fifo_full) begin
          overflow_d = 1'b1;
        end else begin
          wr_ps_d    = WR;
          pkt_done_d = (byte_idx_q == LAST_IDX);
        end
      end
    end else begin
      bit_cnt_d  = '0;
      byte_idx_d = '0;
      if ((rx_ps_q == RX) && ((bit_cnt_q != '0) || (byte_idx_q != '0))) begin
        short_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ps_q    <= IDLE;
      wr_ps_q    <= NO_WR;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      pkt_done_q <= 1'b0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      rx_ps_q    <= rx_ps_d;
      wr_ps_q    <= wr_ps_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      pkt_done_q <= pkt_done_d;
      overflow_q <= overflow_d;
      short_q    <= short_d;
    end
  end

  assign wr_fifo   = (wr_ps_q == WR);
  assign pkt_done  = pkt_done_q;
  assign overflow  = overflow_q;
  assign short_pkt = short_q;

endmodule
